// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing for the fetch stage (boot hold, memory wait, deferred redirect, flush, redirect count).
// Rev 1.0
`default_nettype none

module fetch_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic [DATA_WIDTH-1:0] ALUResultE_i,
  input  logic                  StallF_i,
  input  logic                  IMemAck_i,
  output logic                  PCrst_o,
  output logic                  PCen_o,
  output logic [1:0]            PCSrc_o,
  output logic [DATA_WIDTH-1:0] PCTarget_o,
  output logic                  IMemReq_o,
  output logic                  FetchWait_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic [CNT_WIDTH-1:0]  RedirectCnt_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0]            BOOT_LAST = 8'(BOOT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] LSB_MASK  = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  state_t                  state;
  logic [7:0]              boot_cnt;
  logic                    pending;
  logic [DATA_WIDTH-1:0]   pend_addr;
  logic                    redirect;
  logic [DATA_WIDTH-1:0]   redirect_addr;

  // Redirects are only honoured once the PC has left its boot hold.
  always_comb begin
    redirect      = (state != BOOT) && ((PCSrcE_i == 2'b01) || (PCSrcE_i == 2'b10));
    redirect_addr = (PCSrcE_i == 2'b10) ? (ALUResultE_i & LSB_MASK) : PCTargetE_i;
  end

  assign FlushD_o = redirect;
  assign FlushE_o = redirect;

  always_comb begin
    PCen_o     = 1'b0;
    PCSrc_o    = 2'b00;
    PCTarget_o = pend_addr;
    case (state)
      FETCH: begin
        if (IMemAck_i) begin
          if (redirect) begin
            PCen_o     = 1'b1;
            PCSrc_o    = 2'b01;
            PCTarget_o = redirect_addr;
          end else begin
            PCen_o = !StallF_i;
          end
        end
      end
      WAIT: begin
        // A live redirect is younger than the deferred one, so it wins.
        if (IMemAck_i) begin
          if (redirect) begin
            PCen_o     = 1'b1;
            PCSrc_o    = 2'b01;
            PCTarget_o = redirect_addr;
          end else if (pending) begin
            PCen_o     = 1'b1;
            PCSrc_o    = 2'b01;
            PCTarget_o = pend_addr;
          end else begin
            PCen_o = !StallF_i;
          end
        end
      end
      default: begin
        PCen_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      boot_cnt    <= 8'd0;
      pending     <= 1'b0;
      pend_addr   <= '0;
      PCrst_o     <= 1'b1;
      IMemReq_o   <= 1'b0;
      FetchWait_o <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            state     <= FETCH;
            PCrst_o   <= 1'b0;
            IMemReq_o <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 8'd1;
          end
        end
        FETCH: begin
          if (!IMemAck_i) begin
            state       <= WAIT;
            FetchWait_o <= 1'b1;
            if (redirect) begin
              pending   <= 1'b1;
              pend_addr <= redirect_addr;
            end
          end
        end
        WAIT: begin
          if (IMemAck_i) begin
            state       <= FETCH;
            FetchWait_o <= 1'b0;
            pending     <= 1'b0;
          end else if (redirect) begin
            pending   <= 1'b1;
            pend_addr <= redirect_addr;
          end
        end
        default: begin
          state       <= BOOT;
          boot_cnt    <= 8'd0;
          pending     <= 1'b0;
          PCrst_o     <= 1'b1;
          IMemReq_o   <= 1'b0;
          FetchWait_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RedirectCnt_o <= '0;
    end else if (PCen_o && (PCSrc_o == 2'b01) && (RedirectCnt_o != {CNT_WIDTH{1'b1}})) begin
      RedirectCnt_o <= RedirectCnt_o + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl (BOOT_CYCLES=4, CNT_WIDTH=4).
// Rev 1.0
`default_nettype none

module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  PCSrcE_i;
  logic [31:0] PCTargetE_i;
  logic [31:0] ALUResultE_i;
  logic        StallF_i;
  logic        IMemAck_i;
  logic        PCrst_o;
  logic        PCen_o;
  logic [1:0]  PCSrc_o;
  logic [31:0] PCTarget_o;
  logic        IMemReq_o;
  logic        FetchWait_o;
  logic        FlushD_o;
  logic        FlushE_o;
  logic [3:0]  RedirectCnt_o;

  fetch_ctrl #(.DATA_WIDTH(32), .BOOT_CYCLES(4), .CNT_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCSrcE_i     (PCSrcE_i),
    .PCTargetE_i  (PCTargetE_i),
    .ALUResultE_i (ALUResultE_i),
    .StallF_i     (StallF_i),
    .IMemAck_i    (IMemAck_i),
    .PCrst_o      (PCrst_o),
    .PCen_o       (PCen_o),
    .PCSrc_o      (PCSrc_o),
    .PCTarget_o   (PCTarget_o),
    .IMemReq_o    (IMemReq_o),
    .FetchWait_o  (FetchWait_o),
    .FlushD_o     (FlushD_o),
    .FlushE_o     (FlushE_o),
    .RedirectCnt_o(RedirectCnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [43:0] val;
    logic [43:0] mask;
  } exp_t;

  localparam logic [43:0] ALL   = {44{1'b1}};
  localparam logic [43:0] NOTGT = ~(44'hFFFFFFFF << 8);

  exp_t        sb[$];
  logic [43:0] obsq[$];
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  exp_cnt = 4'd0;

  // {rst, en, src, tgt, req, wait, flushD, flushE, cnt}
  function automatic logic [43:0] ev(input logic rst, input logic en, input logic [1:0] src,
                                     input logic [31:0] tgt, input logic req, input logic fw,
                                     input logic fl, input logic [3:0] cnt);
    return {rst, en, src, tgt, req, fw, fl, fl, cnt};
  endfunction

  function automatic logic [43:0] obs_vec();
    return {PCrst_o, PCen_o, PCSrc_o, PCTarget_o, IMemReq_o, FetchWait_o,
            FlushD_o, FlushE_o, RedirectCnt_o};
  endfunction

  task automatic bump();
    exp_cnt = (exp_cnt == 4'hF) ? exp_cnt : exp_cnt + 4'd1;
  endtask

  // Drive one cycle's inputs, record expectation and the sampled outputs.
  task automatic step(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                      input logic stall, input logic ack, input logic [43:0] e,
                      input logic [43:0] m);
    exp_t x;
    @(negedge clk);
    PCSrcE_i     = src;
    PCTargetE_i  = tgt;
    ALUResultE_i = alu;
    StallF_i     = stall;
    IMemAck_i    = ack;
    x.val  = e;
    x.mask = m;
    sb.push_back(x);
    #1;
    obsq.push_back(obs_vec());
  endtask

  task automatic test_reset();
    exp_t x;
    logic [43:0] o;
    step(2'b01, 32'h100, 32'h0, 1'b0, 1'b1, ev(1, 0, 2'b00, 32'h0, 0, 0, 0, 4'd0), ALL);
    step(2'b10, 32'h0, 32'h203, 1'b1, 1'b0, ev(1, 0, 2'b00, 32'h0, 0, 0, 0, 4'd0), ALL);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obsq.pop_front();
      total++;
      if ((o & x.mask) !== (x.val & x.mask)) begin
        bad++;
        $display("FAIL reset: got %h want %h", o, x.val);
      end
    end
  endtask

  task automatic test_boot();
    exp_t x;
    logic [43:0] o;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(2'b01, 32'h500, 32'h0, 1'b0, 1'b1, ev(1, 0, 2'b00, 32'h0, 0, 0, 0, 4'd0), ALL);
    for (int i = 0; i < 3; i++)
      step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, ev(0, 1, 2'b00, 32'h0, 1, 0, 0, exp_cnt), ALL);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obsq.pop_front();
      total++;
      if ((o & x.mask) !== (x.val & x.mask)) begin
        bad++;
        $display("FAIL boot: got %h want %h", o, x.val);
      end
    end
  endtask

  task automatic test_redirect();
    exp_t x;
    logic [43:0] o;
    step(2'b01, 32'h100, 32'h0, 1'b0, 1'b1, ev(0, 1, 2'b01, 32'h100, 1, 0, 1, exp_cnt), ALL);
    bump();
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, ev(0, 1, 2'b00, 32'h0, 1, 0, 0, exp_cnt), ALL);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obsq.pop_front();
      total++;
      if ((o & x.mask) !== (x.val & x.mask)) begin
        bad++;
        $display("FAIL redirect: got %h want %h", o, x.val);
      end
    end
  endtask

  task automatic test_jalr_stall();
    exp_t x;
    logic [43:0] o;
    step(2'b10, 32'h0, 32'h203, 1'b1, 1'b1, ev(0, 1, 2'b01, 32'h202, 1, 0, 1, exp_cnt), ALL);
    bump();
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, ev(0, 0, 2'b00, 32'h0, 1, 0, 0, exp_cnt), ALL);
    step(2'b11, 32'h77, 32'h0, 1'b0, 1'b1, ev(0, 1, 2'b00, 32'h0, 1, 0, 0, exp_cnt), ALL);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obsq.pop_front();
      total++;
      if ((o & x.mask) !== (x.val & x.mask)) begin
        bad++;
        $display("FAIL jalr_stall: got %h want %h", o, x.val);
      end
    end
  endtask

  task automatic test_wait();
    exp_t x;
    logic [43:0] o;
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, ev(0, 0, 2'b00, 32'h0, 1, 0, 0, exp_cnt), ALL);
    step(2'b01, 32'h40, 32'h0, 1'b0, 1'b0, ev(0, 0, 2'b00, 32'h0, 1, 1, 1, exp_cnt), ALL);
    step(2'b01, 32'h80, 32'h0, 1'b0, 1'b0, ev(0, 0, 2'b00, 32'h40, 1, 1, 1, exp_cnt), ALL);
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, ev(0, 1, 2'b01, 32'h80, 1, 1, 0, exp_cnt), ALL);
    bump();
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, ev(0, 1, 2'b00, 32'h80, 1, 0, 0, exp_cnt), ALL);
    // live redirect in the ack cycle outranks the deferred one
    step(2'b01, 32'h300, 32'h0, 1'b0, 1'b0, ev(0, 0, 2'b00, 32'h80, 1, 0, 1, exp_cnt), ALL);
    step(2'b01, 32'h10, 32'h0, 1'b1, 1'b1, ev(0, 1, 2'b01, 32'h10, 1, 1, 1, exp_cnt), ALL);
    bump();
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obsq.pop_front();
      total++;
      if ((o & x.mask) !== (x.val & x.mask)) begin
        bad++;
        $display("FAIL wait: got %h want %h", o, x.val);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    exp_t x;
    logic [43:0] o;
    step(2'b10, 32'h0, 32'h55, 1'b0, 1'b0, ev(0, 0, 2'b00, 32'h0, 1, 0, 1, exp_cnt), NOTGT);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, ev(0, 0, 2'b00, 32'h54, 1, 1, 0, exp_cnt), ALL);
    @(posedge clk);
    #2;
    PCSrcE_i    = 2'b01;
    PCTargetE_i = 32'h999;
    IMemAck_i   = 1'b1;
    rst_n       = 1'b0;
    exp_cnt     = 4'd0;
    x.val  = ev(1, 0, 2'b00, 32'h0, 0, 0, 0, 4'd0);
    x.mask = ALL;
    sb.push_back(x);
    #1;
    obsq.push_back(obs_vec());
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, ev(1, 0, 2'b00, 32'h0, 0, 0, 0, 4'd0), ALL);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, ev(0, 1, 2'b00, 32'h0, 1, 0, 0, 4'd0), ALL);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obsq.pop_front();
      total++;
      if ((o & x.mask) !== (x.val & x.mask)) begin
        bad++;
        $display("FAIL reset_in_wait: got %h want %h", o, x.val);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t x;
    logic [43:0] o;
    for (int i = 0; i < 18; i++) begin
      step(2'b01, 32'(i * 4 + 8), 32'h0, 1'b0, 1'b1,
           ev(0, 1, 2'b01, 32'(i * 4 + 8), 1, 0, 1, exp_cnt), ALL);
      bump();
    end
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, ev(0, 1, 2'b00, 32'h0, 1, 0, 0, 4'hF), ALL);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obsq.pop_front();
      total++;
      if ((o & x.mask) !== (x.val & x.mask)) begin
        bad++;
        $display("FAIL saturate: got %h want %h", o, x.val);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    PCSrcE_i     = 2'b00;
    PCTargetE_i  = 32'h0;
    ALUResultE_i = 32'h0;
    StallF_i     = 1'b0;
    IMemAck_i    = 1'b0;
    test_reset();
    test_boot();
    test_redirect();
    test_jalr_stall();
    test_wait();
    test_reset_in_wait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
